sd_sector_responder: RTL and testbench
======================================

SD_SECTOR_RESPONDER -- requirements
Module: sd_sector_responder

Interface
REQ-001 SHALL have parameter SECTORS, default 16: number of valid 512-byte sectors in the backing store.
REQ-002 SHALL have port clk_sys  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port sd_lba  in  32  sector number of the pending request.
REQ-005 SHALL have port sd_rd  in  1  level read request from the core.
REQ-006 SHALL have port sd_wr  in  1  level write request from the core.
REQ-007 SHALL have port sd_ack  out  1  high for the whole sector transfer.
REQ-008 SHALL have port sd_buff_addr  out  8  16-bit word index inside the sector.
REQ-009 SHALL have port sd_buff_dout  out  16  read data to the core buffer.
REQ-010 SHALL have port sd_buff_din  in  16  write data from the core buffer; the core buffer has 1-cycle registered read latency.
REQ-011 SHALL have port sd_buff_wr  out  1  one-cycle strobe qualifying sd_buff_dout.
REQ-012 SHALL have port mem_addr  out  24  backing-store word address = {sd_lba[15:0], word[7:0]}.
REQ-013 SHALL have port mem_we  out  1  1 = write, 0 = read, for the current mem_req toggle.
REQ-014 SHALL have port mem_wdata  out  16  backing-store write data.
REQ-015 SHALL have port mem_rdata  in  16  backing-store read data, valid when mem_ack == mem_req.
REQ-016 SHALL have port mem_req  out  1  toggle handshake request; one toggle per word.
REQ-017 SHALL have port mem_ack  in  1  toggle handshake acknowledge; the access completes when mem_ack equals mem_req.
REQ-018 SHALL have port busy  out  1  high from request acceptance until return to IDLE.
REQ-019 SHALL have port oor  out  1  one-cycle pulse when an accepted request has sd_lba >= SECTORS.

Function
REQ-020 SHALL implement states IDLE, ACK, RD_MEM, RD_PUSH, WR_ADDR, WR_WAIT, WR_MEM, DONE.
REQ-021 IDLE: the block SHALL accept a request when (sd_rd|sd_wr) is high and the armed flag is set; it latches sd_lba, latches op (read if sd_rd, giving sd_rd priority when both are high), clears the word counter, sets busy, and goes to ACK.
REQ-022 The armed flag SHALL be cleared on acceptance and set again only after sd_rd and sd_wr have both been sampled low for at least one cycle; a request held high across DONE SHALL NOT start a second transfer.
REQ-023 ACK: the block SHALL raise sd_ack and go to RD_MEM (read) or WR_ADDR (write) next cycle; sd_ack SHALL stay high until DONE.
REQ-024 RD_MEM: the block SHALL toggle mem_req with mem_we=0, then wait until mem_ack == mem_req and capture mem_rdata into sd_buff_dout; for an out-of-range sector it SHALL skip the memory access and load 16'h0000.
REQ-025 RD_PUSH: the block SHALL drive sd_buff_addr = word and pulse sd_buff_wr for exactly one cycle; if word == 255 it goes to DONE, otherwise it increments word and returns to RD_MEM.
REQ-026 WR_ADDR/WR_WAIT: the block SHALL drive sd_buff_addr = word and sample sd_buff_din exactly two clocks after sd_buff_addr changes.
REQ-027 WR_MEM: the block SHALL toggle mem_req with mem_we=1 and mem_wdata = sampled word, then wait for mem_ack == mem_req; out-of-range sectors SHALL skip the memory access (write discarded). After word 255 it goes to DONE, otherwise it increments word and returns to WR_ADDR.
REQ-028 DONE: the block SHALL drop sd_ack and busy and return to IDLE in one cycle.
REQ-029 Exactly 256 words SHALL be transferred per request regardless of range; mem_req SHALL toggle exactly 256 times per in-range sector and 0 times per out-of-range sector.
REQ-030 oor SHALL pulse in the cycle after acceptance when latched sd_lba >= SECTORS; the compare SHALL use the full 32 bits.
REQ-031 mem_addr, mem_we and mem_wdata SHALL be stable from a mem_req toggle until the matching ack.
REQ-032 sd_buff_wr SHALL never be asserted during a write transfer.
REQ-033 Changes on sd_lba, sd_rd and sd_wr while busy SHALL be ignored.

Reset
REQ-034 On reset_n low, asynchronously: state=IDLE; sd_ack=0, sd_buff_wr=0, busy=0, oor=0, mem_req=0, mem_we=0, sd_buff_addr=0, sd_buff_dout=0, mem_addr=0, mem_wdata=0; armed=1.
REQ-035 Reset mid-transfer SHALL abort the transfer with no further mem_req toggles; mem_ack is then treated as resynchronised when it equals mem_req (0).

Verification
REQ-036 Read lba=3, memory word k = 16'h0300+k, ack 2 cycles later -> 256 sd_buff_wr strobes with addr k and data 16'h0300+k, then sd_ack falls once.
REQ-037 Write lba=15, core buffer word k = ~k -> 256 mem writes at mem_addr 24'h000F00+k with data ~k; sd_buff_wr stays 0 throughout.
REQ-038 Read lba=16 with SECTORS=16 -> one oor pulse, 256 strobes of 16'h0000, zero mem_req toggles.
REQ-039 sd_rd held high through DONE -> no second sd_ack until sd_rd goes low and high again; sd_rd and sd_wr both high -> a read is performed.
REQ-040 reset_n low at word 100 of a write -> all outputs reset immediately; a subsequent read of lba=0 completes normally with 256 mem_req toggles.

Source files
------------

// File: rtl/sd_sector_responder.sv
`default_nettype none
// ============================================================================
// sd_sector_responder
//   Serves 256-word SD sector reads/writes from a toggle-handshake store.
//   Revision: 1.0
// ============================================================================
module sd_sector_responder #(
  parameter int SECTORS = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [7:0]  sd_buff_addr,
  output logic [15:0] sd_buff_dout,
  input  logic [15:0] sd_buff_din,
  output logic        sd_buff_wr,
  output logic [23:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        busy,
  output logic        oor
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ACK     = 3'd1;
  localparam logic [2:0] RD_MEM  = 3'd2;
  localparam logic [2:0] RD_PUSH = 3'd3;
  localparam logic [2:0] WR_ADDR = 3'd4;
  localparam logic [2:0] WR_WAIT = 3'd5;
  localparam logic [2:0] WR_MEM  = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  localparam logic [31:0] SECTORS_W = SECTORS;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [15:0] lba;
  logic        op_rd;
  logic        oor_flag;
  logic        armed;
  logic [7:0]  word;
  logic        accept;
  logic        word_done;
  logic        last_word;

  assign accept    = (sd_rd | sd_wr) & armed;
  // Out-of-range sectors never issue a toggle, so they complete immediately.
  assign word_done = oor_flag | (mem_ack == mem_req);
  assign last_word = (word == 8'hFF);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACK;
      ACK:     state_next = op_rd ? RD_MEM : WR_ADDR;
      RD_MEM:  if (word_done) state_next = RD_PUSH;
      RD_PUSH: state_next = last_word ? DONE : RD_MEM;
      WR_ADDR: state_next = WR_WAIT;
      WR_WAIT: state_next = WR_MEM;
      WR_MEM:  if (word_done) state_next = last_word ? DONE : WR_ADDR;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE) && (state != DONE);
    sd_ack     = busy;
    sd_buff_wr = (state == RD_PUSH);
    oor        = (state == ACK) && oor_flag;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lba          <= '0;
      op_rd        <= 1'b0;
      oor_flag     <= 1'b0;
      armed        <= 1'b1;
      word         <= '0;
      sd_buff_addr <= '0;
      sd_buff_dout <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      mem_req      <= 1'b0;
    end else begin
      // Re-arm only once the core has released both request lines.
      if (!sd_rd && !sd_wr) armed <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          lba      <= sd_lba[15:0];
          op_rd    <= sd_rd;
          oor_flag <= (sd_lba >= SECTORS_W);
          word     <= '0;
          armed    <= 1'b0;
        end
        ACK: begin
          if (op_rd) begin
            mem_addr <= {lba, word};
            mem_we   <= 1'b0;
            if (!oor_flag) mem_req <= ~mem_req;
          end else begin
            sd_buff_addr <= word;
          end
        end
        RD_MEM: if (word_done) begin
          sd_buff_dout <= oor_flag ? 16'h0000 : mem_rdata;
          sd_buff_addr <= word;
        end
        RD_PUSH: if (!last_word) begin
          word     <= word + 8'd1;
          mem_addr <= {lba, word + 8'd1};
          mem_we   <= 1'b0;
          if (!oor_flag) mem_req <= ~mem_req;
        end
        // Core buffer data is valid two clocks after the address moved.
        WR_WAIT: begin
          mem_wdata <= sd_buff_din;
          mem_addr  <= {lba, word};
          mem_we    <= 1'b1;
          if (!oor_flag) mem_req <= ~mem_req;
        end
        WR_MEM: if (word_done && !last_word) begin
          word         <= word + 8'd1;
          sd_buff_addr <= word + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_responder.sv
`default_nettype none
// Bench for sd_sector_responder: table of sector transactions plus
// hand-written armed-flag and mid-transfer reset sequences.
module tb_sd_sector_responder;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] sd_lba = '0;
  logic        sd_rd = 1'b0;
  logic        sd_wr = 1'b0;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic [15:0] sd_buff_din = '0;
  logic        sd_buff_wr;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        oor;

  sd_sector_responder #(.SECTORS(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
    .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_req(mem_req),
    .mem_ack(mem_ack), .busy(busy), .oor(oor)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;

  // Per-transaction observations
  int toggles, strobes, writes, oor_pulses, ack_rises, data_err, stab_err;
  logic [31:0] cur_lba = '0;
  bit          cur_oor = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Core buffer: word k holds ~k, one-cycle registered read.
  always @(posedge clk_sys) sd_buff_din <= ~{8'h00, sd_buff_addr};

  // Backing store: acknowledges two cycles after a toggle.
  int  dly = 0;
  bit  pend = 1'b0;
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      pend = 1'b0;
      mem_ack = 1'b0;
    end else if (pend) begin
      dly--;
      if (dly == 0) begin
        if (mem_we) begin
          if (mem_addr !== {cur_lba[15:0], writes[7:0]} || mem_wdata !== ~{8'h00, writes[7:0]})
            data_err++;
          writes++;
        end else begin
          mem_rdata = mem_addr[15:0];
        end
        mem_ack = mem_req;
        pend = 1'b0;
      end
    end else if (mem_req != mem_ack) begin
      pend = 1'b1;
      dly = 2;
    end
  end

  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [23:0] s_addr;
  logic        s_we;
  logic [15:0] s_wdata;
  always @(negedge clk_sys) begin
    if (reset_n && mem_req != prev_req) begin
      toggles++;
      s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
    end else if (reset_n && mem_req != mem_ack) begin
      if (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata) stab_err++;
    end
    prev_req = mem_req;
    if (sd_buff_wr) begin
      if (sd_buff_addr !== strobes[7:0] ||
          sd_buff_dout !== (cur_oor ? 16'h0000 : {cur_lba[7:0], strobes[7:0]}))
        data_err++;
      strobes++;
    end
    if (oor) oor_pulses++;
    if (sd_ack && !prev_ack) ack_rises++;
    prev_ack = sd_ack;
  end

  task automatic clear_counts(input logic [31:0] lba, input bit is_oor);
    @(posedge clk_sys); #2;
    toggles = 0; strobes = 0; writes = 0; oor_pulses = 0;
    ack_rises = 0; data_err = 0; stab_err = 0;
    cur_lba = lba; cur_oor = is_oor;
  endtask

  task automatic wait_busy(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_sys);
      if (busy === level) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_txn(input string tag, input logic rd, input logic wr, input logic [31:0] lba,
                         input bit exp_oor, input int exp_toggles, input int exp_strobes,
                         input int exp_writes);
    bit ok;
    clear_counts(lba, exp_oor);
    @(negedge clk_sys);
    sd_rd = rd; sd_wr = wr; sd_lba = lba;
    wait_busy(1'b1, 10, ok);
    check({tag, "_start"}, ok, 1);
    sd_lba = ~lba;
    wait_busy(1'b0, 4000, ok);
    check({tag, "_end"}, ok, 1);
    sd_rd = 1'b0; sd_wr = 1'b0;
    repeat (4) @(negedge clk_sys);
    check({tag, "_toggles"}, toggles, exp_toggles);
    check({tag, "_strobes"}, strobes, exp_strobes);
    check({tag, "_writes"}, writes, exp_writes);
    check({tag, "_oor"}, oor_pulses, exp_oor ? 1 : 0);
    check({tag, "_ack_rises"}, ack_rises, 1);
    check({tag, "_data_err"}, data_err, 0);
    check({tag, "_stable_err"}, stab_err, 0);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    bit          exp_oor;
    int          exp_toggles;
    int          exp_strobes;
    int          exp_writes;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    vecs[0] = '{1'b1, 1'b0, 32'd3,          1'b0, 256, 256, 0};
    vecs[1] = '{1'b0, 1'b1, 32'd15,         1'b0, 256, 0,   256};
    vecs[2] = '{1'b1, 1'b0, 32'd16,         1'b1, 0,   256, 0};
    vecs[3] = '{1'b1, 1'b1, 32'd5,          1'b0, 256, 256, 0};
    vecs[4] = '{1'b0, 1'b1, 32'h0001_0002,  1'b1, 0,   0,   0};
    vecs[5] = '{1'b1, 1'b0, 32'd15,         1'b0, 256, 256, 0};

    repeat (2) @(negedge clk_sys);
    check("reset_ctrl", {sd_ack, busy, oor, sd_buff_wr, mem_req, mem_we}, 0);
    check("reset_data", {sd_buff_addr, sd_buff_dout, mem_addr, mem_wdata}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("v%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].lba, vecs[i].exp_oor,
              vecs[i].exp_toggles, vecs[i].exp_strobes, vecs[i].exp_writes);

    // Request held high across DONE must not restart until released.
    clear_counts(32'd1, 1'b0);
    @(negedge clk_sys);
    sd_rd = 1'b1; sd_lba = 32'd1;
    wait_busy(1'b1, 10, ok);
    check("hold_start", ok, 1);
    wait_busy(1'b0, 4000, ok);
    check("hold_end", ok, 1);
    repeat (20) @(negedge clk_sys);
    check("hold_no_rearm", {busy, ack_rises[7:0]}, 1);
    sd_rd = 1'b0;
    @(negedge clk_sys);
    sd_rd = 1'b1;
    wait_busy(1'b1, 10, ok);
    check("rearm_start", ok, 1);
    wait_busy(1'b0, 4000, ok);
    sd_rd = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rearm_ack_rises", ack_rises, 2);
    check("rearm_toggles", toggles, 512);

    // Reset in the middle of a write.
    clear_counts(32'd4, 1'b0);
    @(negedge clk_sys);
    sd_wr = 1'b1; sd_lba = 32'd4;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_sys);
      if (writes == 100) begin ok = 1'b1; break; end
    end
    check("mid_reach_word100", ok, 1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_ctrl", {sd_ack, busy, oor, sd_buff_wr, mem_req, mem_we}, 0);
    check("mid_reset_data", {sd_buff_addr, sd_buff_dout, mem_addr, mem_wdata}, 0);
    repeat (3) @(negedge clk_sys);
    sd_wr = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("mid_no_restart", busy, 0);
    run_txn("post_reset_rd0", 1'b1, 1'b0, 32'd0, 1'b0, 256, 256, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
